// File: rtl/booth_mul_pkg.sv
// Shared types and defaults for the two-requester Booth multiplier arbiter.
package booth_mul_pkg;
  localparam int MUL_LAT_DEF    = 2;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int ID_W           = 1;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [127:0]    result;
  } rsp_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/booth_mul_arbiter_if.sv
// Request/response bundle between the two requesters, the consumer and the arbiter.
interface booth_mul_arbiter_if;
  logic         req0_valid_i;
  logic         req1_valid_i;
  logic         req0_ready_o;
  logic         req1_ready_o;
  logic [63:0]  req0_a_i;
  logic [63:0]  req0_b_i;
  logic [63:0]  req1_a_i;
  logic [63:0]  req1_b_i;
  logic         rsp_valid_o;
  logic         rsp_ready_i;
  logic         rsp_id_o;
  logic [127:0] rsp_result_o;
  logic         busy_o;

  modport master (
    output req0_valid_i, req1_valid_i, req0_a_i, req0_b_i, req1_a_i, req1_b_i, rsp_ready_i,
    input  req0_ready_o, req1_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o, busy_o
  );

  modport slave (
    input  req0_valid_i, req1_valid_i, req0_a_i, req0_b_i, req1_a_i, req1_b_i, rsp_ready_i,
    output req0_ready_o, req1_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o, busy_o
  );
endinterface

// File: rtl/Booth_Multiplier_64_signed.sv
// Radix-4 Booth signed 64x64 multiplier; product emerges LAT register stages after the operands.
module Booth_Multiplier_64_signed #(
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic [63:0]  a_i,
  input  logic [63:0]  b_i,
  output logic [127:0] result_o
);
  logic [127:0] a_ext;
  logic [64:0]  b_ext;
  logic [127:0] prod;
  logic [127:0] pipe [LAT];

  always_comb begin
    a_ext = {{64{a_i[63]}}, a_i};
    b_ext = {b_i, 1'b0};
    prod  = '0;
    for (int i = 0; i < 32; i++) begin
      case (b_ext[2*i +: 3])
        3'b001, 3'b010: prod = prod + (a_ext << (2*i));
        3'b011:         prod = prod + (a_ext << (2*i + 1));
        3'b100:         prod = prod - (a_ext << (2*i + 1));
        3'b101, 3'b110: prod = prod - (a_ext << (2*i));
        default:        prod = prod;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    pipe[0] <= prod;
    for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
  end

  assign result_o = pipe[LAT-1];
endmodule

// File: rtl/mul_rsp_fifo.sv
// Response FIFO holding {id, product}; pointers carry a wrap bit so occupancy is exact.
module mul_rsp_fifo
  import booth_mul_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_en,
  input  rsp_t wr_data,
  input  logic rd_en,
  output rsp_t rd_data,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  rsp_t        mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [AW:0] occ;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) begin
        mem[wptr[AW-1:0]] <= wr_data;
        wptr              <= wptr + 1'b1;
      end
      if (rd_en) rptr <= rptr + 1'b1;
    end
  end

  assign occ     = wptr - rptr;
  assign empty   = (occ == '0);
  assign rd_data = mem[rptr[AW-1:0]];
endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter feeding a shared pipelined Booth multiplier; credits bound
// outstanding work to the response FIFO depth so the FIFO can never overflow.
module booth_mul_arbiter
  import booth_mul_pkg::*;
#(
  parameter int MUL_LAT    = MUL_LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  booth_mul_arbiter_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0] outstanding;
  logic          last_gnt1;
  tag_t          tag_pipe [MUL_LAT];
  logic          credit_ok, pick0, pick1, gnt0, gnt1, issue, pop;
  logic [63:0]   mul_a, mul_b;
  logic [127:0]  mul_result;
  rsp_t          fifo_wr, fifo_head;
  logic          fifo_empty;

  // Ready never looks at rsp_ready_i: a credit freed by a pop is usable next cycle.
  assign credit_ok = outstanding < CW'(FIFO_DEPTH);
  assign pick1     = bus.req1_valid_i && (!bus.req0_valid_i || !last_gnt1);
  assign pick0     = bus.req0_valid_i && !pick1;
  assign gnt0      = !rst && credit_ok && pick0;
  assign gnt1      = !rst && credit_ok && pick1;
  assign issue     = gnt0 || gnt1;

  assign bus.req0_ready_o = gnt0;
  assign bus.req1_ready_o = gnt1;

  assign mul_a = gnt0 ? bus.req0_a_i : (gnt1 ? bus.req1_a_i : '0);
  assign mul_b = gnt0 ? bus.req0_b_i : (gnt1 ? bus.req1_b_i : '0);

  assign bus.rsp_valid_o  = !rst && !fifo_empty;
  assign pop              = bus.rsp_valid_o && bus.rsp_ready_i;
  assign bus.rsp_id_o     = bus.rsp_valid_o ? fifo_head.id : 1'b0;
  assign bus.rsp_result_o = bus.rsp_valid_o ? fifo_head.result : '0;
  assign bus.busy_o       = !rst && (outstanding != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      last_gnt1   <= 1'b1;
      for (int s = 0; s < MUL_LAT; s++) tag_pipe[s] <= '0;
    end else begin
      case ({issue, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (issue) last_gnt1 <= gnt1;
      tag_pipe[0] <= '{valid: issue, id: gnt1};
      for (int s = 1; s < MUL_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  Booth_Multiplier_64_signed #(.LAT(MUL_LAT)) u_mul (
    .clk      (clk),
    .a_i      (mul_a),
    .b_i      (mul_b),
    .result_o (mul_result)
  );

  assign fifo_wr = '{id: tag_pipe[MUL_LAT-1].id, result: mul_result};

  mul_rsp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tag_pipe[MUL_LAT-1].valid),
    .wr_data (fifo_wr),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .empty   (fifo_empty)
  );
endmodule

// File: doc/booth_mul_arbiter.md
BOOTH_MUL_ARBITER -- requirements
Module: booth_mul_arbiter

Interface
REQ-001 SHALL have parameter MUL_LAT, default 2, cycles from operands presented to the multiplier until result_o is valid.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, depth of the response FIFO and the maximum number of outstanding operations (power of two, >=2).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports req0_valid_i / req1_valid_i  input  1 each  requester N has an operation pending.
REQ-006 SHALL have ports req0_ready_o / req1_ready_o  output  1 each  requester N is accepted this cycle.
REQ-007 SHALL have ports req0_a_i, req0_b_i, req1_a_i, req1_b_i  input  64 each  signed two's-complement operands.
REQ-008 SHALL have port rsp_valid_o  output  1  the response FIFO head is valid.
REQ-009 SHALL have port rsp_ready_i  input  1  the consumer accepts the response.
REQ-010 SHALL have port rsp_id_o  output  1  the requester index (0/1) of the head response.
REQ-011 SHALL have port rsp_result_o  output  128  signed product of the head response.
REQ-012 SHALL have port busy_o  output  1  high while the outstanding count is nonzero.

Function
REQ-013 SHALL complete a request handshake when reqN_valid_i and reqN_ready_o are both high at a rising edge of clk; at most one requester is granted per cycle.
REQ-014 SHALL use round-robin arbitration: a lone valid requester is granted; when both are valid, the requester not granted most recently wins; after reset req0 has priority.
REQ-015 SHALL keep an outstanding count (in flight plus FIFO occupancy) and SHALL grant only when outstanding < FIFO_DEPTH.
REQ-016 SHALL NOT release credit in the same cycle as the response pop; the count updates +1 on issue, -1 on pop, and is unchanged on simultaneous issue and pop.
REQ-017 SHALL have no combinational path from rsp_ready_i to reqN_ready_o; reqN_ready_o may depend on req0_valid_i, req1_valid_i and registered state.
REQ-018 SHALL present the granted operands to the multiplier in the cycle of acceptance, and SHALL drive all-zero operands when no grant occurs.
REQ-019 SHALL carry {valid, id} through a MUL_LAT-stage shift register aligned with the multiplier pipeline, and SHALL write {id, result_o} into the FIFO when a valid tag exits.
REQ-020 SHALL, for a handshake at edge k, write the result at edge k+MUL_LAT and assert rsp_valid_o in the following cycle if the FIFO was empty (minimum latency MUL_LAT+1 cycles).
REQ-021 SHALL return responses in issue order, one per cycle maximum, and SHALL hold rsp_* stable while rsp_valid_o is high and rsp_ready_i is low.
REQ-022 SHALL sustain 1 issue per cycle when rsp_ready_i is held high.
REQ-023 SHALL compute the full-width signed product with no truncation: -2^63 * -1 = +2^63.
REQ-024 SHALL never overflow or underflow the FIFO; the bench SHALL assert this.

Reset
REQ-025 SHALL, while rst is high, clear the outstanding count, tag valids, FIFO pointers and the round-robin pointer (req0 priority), and SHALL drive reqN_ready_o=0, rsp_valid_o=0, rsp_id_o=0, rsp_result_o=0 and busy_o=0.
REQ-026 SHALL discard in-flight operations when reset is asserted mid-operation; no stale response SHALL emerge after reset deasserts, even while multiplier outputs settle.
REQ-027 SHALL accept a new request on the first cycle after rst deasserts.

Structure
REQ-028 SHALL place MUL_LAT and FIFO_DEPTH defaults, the requester-id width and the response record {id, 128-bit result} in the shared package booth_mul_pkg.
REQ-029 SHALL instantiate Booth_Multiplier_64_signed unchanged, and SHALL implement the response FIFO as sub-module mul_rsp_fifo.

Verification
REQ-030 SHALL cover: req0 a=-36, b=42 alone -> rsp_id_o=0 and rsp_result_o=-1512, 3 cycles after acceptance.
REQ-031 SHALL cover: both requesters valid every cycle with rsp_ready_i=1 -> grants alternate 0,1,0,1, results are in order, and throughput is 1 per cycle.
REQ-032 SHALL cover: rsp_ready_i=0 with req0 continuous -> exactly 4 accepted, then req0_ready_o=0; releasing rsp_ready_i drains 4 responses, then issue resumes.
REQ-033 SHALL cover: -2^63*-1 and -2^63*1 -> results 2^63 and -2^63 (128-bit sign-extended).
REQ-034 SHALL cover: rst pulsed with 3 operations in flight -> no rsp_valid_o afterwards, busy_o=0, next grant to req0.
REQ-035 SHALL cover: outstanding=3 with simultaneous issue and pop -> count stays 3 and ready remains high next cycle.
